ica_iter_ctrl: RTL and testbench

Iteration scheduler for the one-unit FastICA engine, one level above the fast controller. A single `start` launches up to MAX_ITER iterations. Each iteration restarts the fast controller through `go_fast`, waits for `fast_busy` to fall, then runs the normalization unit and the convergence check through request/done handshakes. The block stops on convergence, on reaching the iteration limit, or on `abort`, and reports status to the host.

---
 rtl/ica_pkg.sv | 25 ++
 rtl/ica_iter_ctrl_if.sv | 45 ++++
 rtl/ica_wait_timer.sv | 38 +++
 rtl/ica_iter_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ica_iter_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ica_pkg.sv
// Shared definitions for the FastICA iteration scheduler.
//   ica_state_e      : 3-bit scheduler state encoding (also exported on dbg_state)
//   ICA_MAX_ITER_DEF : default iteration limit per run
//   ICA_TIMEOUT_DEF  : default watchdog limit (cycles per wait state)
//   is_wait_state()  : true for the states that wait on an external unit
package ica_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KICK     = 3'd1,
        ST_RUN_FAST = 3'd2,
        ST_NORM     = 3'd3,
        ST_CONV     = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } ica_state_e;

    localparam int ICA_MAX_ITER_DEF = 16;
    localparam int ICA_TIMEOUT_DEF  = 1023;

    function automatic logic is_wait_state(input ica_state_e s);
        return (s == ST_RUN_FAST) || (s == ST_NORM) || (s == ST_CONV);
    endfunction

endpackage

// File: rtl/ica_iter_ctrl_if.sv
// Engine-side handshake bundle between the iteration scheduler and the
// fast controller, normalization unit and convergence checker.
//   go_fast    : run enable for the fast controller (0 parks it in INIT)
//   fast_busy  : fast controller busy flag
//   norm_start : one-cycle request to the normalization unit
//   norm_done  : normalization complete
//   conv_start : one-cycle request to the convergence checker
//   conv_done  : convergence check complete
//   conv_ok    : convergence result, qualified by conv_done
//
// Handshake semantics: a request (norm_start/conv_start) is a single-cycle
// pulse issued on entry to the matching wait state; the unit answers with a
// done pulse (or level) that is only honoured while the scheduler sits in that
// wait state, and conv_ok is only looked at in the cycle conv_done is high.
// go_fast is a level: the fast run proceeds while it is high and fast_busy
// falling to 0 is the completion event.
interface ica_iter_ctrl_if;
    logic go_fast;
    logic fast_busy;
    logic norm_start;
    logic norm_done;
    logic conv_start;
    logic conv_done;
    logic conv_ok;

    modport master (
        output go_fast,
        output norm_start,
        output conv_start,
        input  fast_busy,
        input  norm_done,
        input  conv_done,
        input  conv_ok
    );

    modport slave (
        input  go_fast,
        input  norm_start,
        input  conv_start,
        output fast_busy,
        output norm_done,
        output conv_done,
        output conv_ok
    );
endinterface

// File: rtl/ica_wait_timer.sv
// Watchdog counter for one wait state of the iteration scheduler.
// Only instantiated when ICA_TIMEOUT_EN is defined.
//   clk_iter, rst_iter : clock, asynchronous active-high reset
//   clear              : restart the count (entry into a wait state)
//   enable             : count this cycle (currently in a wait state)
//   limit              : number of cycles allowed in the wait state (>= 1)
//   expired            : the current cycle is the last one allowed
module ica_wait_timer #(
    parameter int TMR_W = 10
) (
    input  logic             clk_iter,
    input  logic             rst_iter,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMR_W-1:0] limit,
    output logic             expired
);

    logic [TMR_W-1:0] cnt;

    // cnt = cycles already spent in the state before the current one, so the
    // limit-th cycle shows cnt == limit-1 and the scheduler leaves at the edge
    // closing that cycle. The count saturates rather than wrapping.
    always_ff @(posedge clk_iter or posedge rst_iter) begin
        if (rst_iter) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != limit)) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    // Must not depend on clear: clear is derived from the next state, which
    // itself depends on expired.
    assign expired = enable && (cnt == (limit - TMR_W'(1)));

endmodule

// File: rtl/ica_iter_ctrl.sv
// Iteration scheduler for the one-unit FastICA engine.
// A start pulse launches up to MAX_ITER iterations; each iteration kicks the
// fast controller (go_fast low for one cycle), waits for fast_busy to fall,
// then runs normalization and the convergence check. Stops on convergence,
// on the iteration limit, or on abort.
//
// Optional feature macro: ICA_TIMEOUT_EN adds a per-wait-state watchdog
// (ica_wait_timer) and the ERR state. Without it timeout_err is tied to 0.
//
// Ports:
//   clk_iter, rst_iter : clock, asynchronous active-high reset
//   start              : begin a run (accepted in IDLE, DONE, ERR)
//   abort              : synchronous abort to IDLE, highest priority
//   eng                : engine handshakes (ica_iter_ctrl_if.master)
//   busy               : high in KICK, RUN_FAST, NORM, CONV
//   done               : high while in DONE
//   converged          : result of the last run, valid while done
//   iter_cnt           : completed iterations in the current run
//   timeout_err        : high while in ERR
//   dbg_state          : current scheduler state
module ica_iter_ctrl
    import ica_pkg::*;
#(
    parameter int MAX_ITER = ICA_MAX_ITER_DEF,
    parameter int ITER_W   = 5,
    parameter int TIMEOUT  = ICA_TIMEOUT_DEF,
    parameter int TMR_W    = 10
) (
    input  logic              clk_iter,
    input  logic              rst_iter,
    input  logic              start,
    input  logic              abort,
    ica_iter_ctrl_if.master   eng,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              timeout_err,
    output ica_state_e        dbg_state
);

    ica_state_e        state, state_n;
    logic [ITER_W-1:0] iter_q, iter_n;
    logic              conv_q, conv_n;
    logic              go_fast_q, norm_start_q, conv_start_q, busy_q, done_q;

`ifdef ICA_TIMEOUT_EN
    logic tmr_clear;
    logic tmr_expired;
    logic timeout_err_q;

    // Restart the watchdog whenever a wait state is freshly entered, including
    // a direct hop from one wait state to the next.
    assign tmr_clear = is_wait_state(state_n) && (state_n != state);

    ica_wait_timer #(
        .TMR_W (TMR_W)
    ) u_wait_timer (
        .clk_iter (clk_iter),
        .rst_iter (rst_iter),
        .clear    (tmr_clear),
        .enable   (is_wait_state(state)),
        .limit    (TMR_W'(TIMEOUT)),
        .expired  (tmr_expired)
    );
`endif

    // Next-state logic. abort beats everything; a done input in its own wait
    // state beats a timeout in the same cycle; start only matters when idle.
    always_comb begin
        state_n = state;
        iter_n  = iter_q;
        conv_n  = conv_q;
        if (abort) begin
            state_n = ST_IDLE;
            iter_n  = '0;
            conv_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_n = ST_KICK;
                        iter_n  = '0;
                        conv_n  = 1'b0;
                    end
                end
                ST_KICK: begin
                    state_n = ST_RUN_FAST;
                end
                ST_RUN_FAST: begin
                    if (!eng.fast_busy) begin
                        state_n = ST_NORM;
                    end
`ifdef ICA_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state_n = ST_ERR;
                    end
`endif
                end
                ST_NORM: begin
                    if (eng.norm_done) begin
                        state_n = ST_CONV;
                    end
`ifdef ICA_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state_n = ST_ERR;
                    end
`endif
                end
                ST_CONV: begin
                    if (eng.conv_done) begin
                        iter_n = iter_q + ITER_W'(1);
                        if (eng.conv_ok) begin
                            state_n = ST_DONE;
                            conv_n  = 1'b1;
                        end else if (iter_n == ITER_W'(MAX_ITER)) begin
                            state_n = ST_DONE;
                            conv_n  = 1'b0;
                        end else begin
                            state_n = ST_KICK;
                        end
                    end
`ifdef ICA_TIMEOUT_EN
                    else if (tmr_expired) begin
                        state_n = ST_ERR;
                    end
`endif
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they change
    // exactly with the state and come straight from flops. Request pulses fire
    // only on the edge that enters their wait state.
    always_ff @(posedge clk_iter or posedge rst_iter) begin
        if (rst_iter) begin
            state        <= ST_IDLE;
            iter_q       <= '0;
            conv_q       <= 1'b0;
            go_fast_q    <= 1'b0;
            norm_start_q <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_n;
            iter_q       <= iter_n;
            conv_q       <= conv_n;
            go_fast_q    <= is_wait_state(state_n);
            norm_start_q <= (state_n == ST_NORM) && (state != ST_NORM);
            conv_start_q <= (state_n == ST_CONV) && (state != ST_CONV);
            busy_q       <= (state_n == ST_KICK) || is_wait_state(state_n);
            done_q       <= (state_n == ST_DONE);
        end
    end

`ifdef ICA_TIMEOUT_EN
    always_ff @(posedge clk_iter or posedge rst_iter) begin
        if (rst_iter) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= (state_n == ST_ERR);
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign eng.go_fast    = go_fast_q;
    assign eng.norm_start = norm_start_q;
    assign eng.conv_start = conv_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign converged      = conv_q;
    assign iter_cnt       = iter_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_ica_iter_ctrl.sv
// Self-checking bench for ica_iter_ctrl. Bench-side units (fast controller,
// normalization, convergence checker) answer with latencies taken from
// per-iteration tables; a run-level model predicts iteration count, result,
// pulse counts and run length from those tables.
module tb_ica_iter_ctrl;
    import ica_pkg::*;

    localparam int MAX_IT = 4;
    localparam int ITER_W = 5;
    localparam int TMO    = 20;
`ifdef ICA_TIMEOUT_EN
    localparam int STD_FAST = 10;
`else
    localparam int STD_FAST = 133;
`endif

    logic              clk_iter;
    logic              rst_iter;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              converged;
    logic [ITER_W-1:0] iter_cnt;
    logic              timeout_err;
    ica_state_e        dbg_state;

    logic r_fast_busy, r_norm_done, r_conv_done, r_conv_ok;
    logic m_norm_done;
    logic auto_en;

    ica_iter_ctrl_if eng_if ();

    assign eng_if.fast_busy = r_fast_busy;
    assign eng_if.norm_done = r_norm_done | m_norm_done;
    assign eng_if.conv_done = r_conv_done;
    assign eng_if.conv_ok   = r_conv_ok;

    ica_iter_ctrl #(
        .MAX_ITER (MAX_IT),
        .ITER_W   (ITER_W),
        .TIMEOUT  (TMO),
        .TMR_W    (10)
    ) dut (
        .clk_iter    (clk_iter),
        .rst_iter    (rst_iter),
        .start       (start),
        .abort       (abort),
        .eng         (eng_if.master),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .iter_cnt    (iter_cnt),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_iter = 1'b0;
        forever #5 clk_iter = ~clk_iter;
    end

    // ---------------- scoreboard state ----------------
    int          lat_f [MAX_IT];
    int          lat_n [MAX_IT];
    int          lat_c [MAX_IT];
    bit          ok_v  [MAX_IT];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_norm   = 0;
    int          n_conv   = 0;
    int          n_kick   = 0;
    logic [31:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse/KICK counters sampled mid-cycle.
    always @(negedge clk_iter) begin
        if (eng_if.norm_start) n_norm++;
        if (eng_if.conv_start) n_conv++;
        if (busy && !eng_if.go_fast) n_kick++;
    end

    // ---------------- bench-side units ----------------
    // Fast controller: busy while parked (go_fast low); busy falls lat_f
    // cycles after go_fast rises.
    initial begin
        int  fcnt;
        bit  fired;
        int  fi;
        r_fast_busy = 1'b1;
        fcnt  = 0;
        fired = 1'b0;
        fi    = 0;
        forever begin
            @(negedge clk_iter);
            if (start) fi = 0;
            if (!eng_if.go_fast) begin
                r_fast_busy = 1'b1;
                fcnt  = 0;
                fired = 1'b0;
            end else if (!fired) begin
                fcnt++;
                if (fcnt > lat_f[fi]) begin
                    r_fast_busy = 1'b0;
                    fired = 1'b1;
                    if (fi < MAX_IT - 1) fi++;
                end
            end
        end
    end

    // Normalization unit: done pulse lat_n cycles after the request.
    initial begin
        int ni;
        ni = 0;
        r_norm_done = 1'b0;
        forever begin
            @(negedge clk_iter);
            if (start) ni = 0;
            if (auto_en && eng_if.norm_start) begin
                repeat (lat_n[ni]) @(negedge clk_iter);
                r_norm_done = 1'b1;
                if (ni < MAX_IT - 1) ni++;
                @(negedge clk_iter);
                r_norm_done = 1'b0;
            end
        end
    end

    // Convergence checker: done pulse lat_c cycles after the request, with
    // the tabled result.
    initial begin
        int ci;
        ci = 0;
        r_conv_done = 1'b0;
        r_conv_ok   = 1'b0;
        forever begin
            @(negedge clk_iter);
            if (start) ci = 0;
            if (auto_en && eng_if.conv_start) begin
                repeat (lat_c[ci]) @(negedge clk_iter);
                r_conv_done = 1'b1;
                r_conv_ok   = ok_v[ci];
                if (ci < MAX_IT - 1) ci++;
                @(negedge clk_iter);
                r_conv_done = 1'b0;
                r_conv_ok   = 1'b0;
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check_reset(input string tag);
        check_val({tag, "_go_fast"}, eng_if.go_fast, 0);
        check_val({tag, "_norm_start"}, eng_if.norm_start, 0);
        check_val({tag, "_conv_start"}, eng_if.conv_start, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_converged"}, converged, 0);
        check_val({tag, "_iter_cnt"}, iter_cnt, 0);
        check_val({tag, "_timeout_err"}, timeout_err, 0);
        check_val({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // Called at a negedge. Predicts the run from the tables, launches it and
    // compares the outcome. Run length model: each iteration costs its three
    // datapath latencies plus 4 cycles of scheduling overhead.
    task automatic run_and_check(input string tag);
        int exp_it, exp_cyc, n, b_norm, b_conv, b_kick;
        bit exp_cv;
        exp_it = MAX_IT;
        exp_cv = 1'b0;
        for (int i = 0; i < MAX_IT; i++) begin
            if (ok_v[i]) begin
                exp_it = i + 1;
                exp_cv = 1'b1;
                break;
            end
        end
        exp_cyc = 0;
        for (int i = 0; i < exp_it; i++) exp_cyc += 4 + lat_f[i] + lat_n[i] + lat_c[i];
        exp_q.push_back(32'(exp_it));
        exp_q.push_back(32'(exp_cv));
        exp_q.push_back(32'(exp_cyc));
        b_norm = n_norm;
        b_conv = n_conv;
        b_kick = n_kick;
        #1 start = 1'b1;
        @(negedge clk_iter);
        check_val({tag, "_kick_state"}, dbg_state, ST_KICK);
        check_val({tag, "_kick_busy"}, busy, 1);
        check_val({tag, "_kick_go_fast"}, eng_if.go_fast, 0);
        #1 start = 1'b0;
        @(negedge clk_iter);
        n = 1;
        check_val({tag, "_run_state"}, dbg_state, ST_RUN_FAST);
        check_val({tag, "_run_go_fast"}, eng_if.go_fast, 1);
        while (!done && n < 4000) begin
            @(negedge clk_iter);
            n++;
        end
        check_val({tag, "_done_seen"}, done, 1);
        check_val({tag, "_iter_cnt"}, iter_cnt, exp_q.pop_front());
        check_val({tag, "_converged"}, converged, exp_q.pop_front());
        check_val({tag, "_cycles"}, n, exp_q.pop_front());
        check_val({tag, "_norm_pulses"}, n_norm - b_norm, exp_it);
        check_val({tag, "_conv_pulses"}, n_conv - b_conv, exp_it);
        check_val({tag, "_kicks"}, n_kick - b_kick, exp_it);
        check_val({tag, "_busy_end"}, busy, 0);
        check_val({tag, "_go_fast_end"}, eng_if.go_fast, 0);
    endtask

    task automatic clear_tables();
        for (int i = 0; i < MAX_IT; i++) begin
            lat_f[i] = 0;
            lat_n[i] = 0;
            lat_c[i] = 0;
            ok_v[i]  = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k, b_conv;
        start       = 1'b0;
        abort       = 1'b0;
        auto_en     = 1'b1;
        m_norm_done = 1'b0;
        rst_iter    = 1'b1;
        clear_tables();

        repeat (3) @(negedge clk_iter);
        check_reset("rst_hold");
        #1 rst_iter = 1'b0;
        @(negedge clk_iter);
        check_reset("rst_idle");

        // Convergence on the third check, first fast run at standard length.
        clear_tables();
        lat_f[0] = STD_FAST; lat_n[0] = 3; lat_c[0] = 2;
        lat_f[1] = 4;        lat_n[1] = 1; lat_c[1] = 0;
        lat_f[2] = 0;        lat_n[2] = 2; lat_c[2] = 5;
        ok_v[2]  = 1'b1;
        run_and_check("conv3");

        // Iteration limit: never converges.
        clear_tables();
        for (int i = 0; i < MAX_IT; i++) begin
            lat_f[i] = 2 + i;
            lat_n[i] = 1;
            lat_c[i] = i;
        end
        run_and_check("limit");

        // Randomized runs, each started from DONE.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < MAX_IT; i++) begin
                lat_f[i] = $urandom_range(0, 8);
                lat_n[i] = $urandom_range(0, 5);
                lat_c[i] = $urandom_range(0, 5);
                ok_v[i]  = ($urandom_range(0, 2) == 0);
            end
            run_and_check($sformatf("rand%0d", r));
        end

        // Abort out of DONE clears the run status.
        #1 abort = 1'b1;
        @(negedge clk_iter);
        check_val("abort_done_state", dbg_state, ST_IDLE);
        check_val("abort_done_iter", iter_cnt, 0);
        check_val("abort_done_conv", converged, 0);
        check_val("abort_done_done", done, 0);
        #1 abort = 1'b0;
        @(negedge clk_iter);

        // Ignored inputs, then abort colliding with norm_done.
        auto_en = 1'b0;
        clear_tables();
        lat_f[0] = 5;
        b_conv = n_conv;
        #1 start = 1'b1;
        @(negedge clk_iter);
        #1 start = 1'b0;
        @(negedge clk_iter);
        #1 m_norm_done = 1'b1;
        @(negedge clk_iter);
        check_val("ign_norm_done_state", dbg_state, ST_RUN_FAST);
        check_val("ign_norm_done_req", eng_if.norm_start, 0);
        #1 m_norm_done = 1'b0;
        k = 0;
        while (!eng_if.norm_start && k < 50) begin
            @(negedge clk_iter);
            k++;
        end
        check_val("ign_norm_entry", k, 5);
        #1 start = 1'b1;
        @(negedge clk_iter);
        check_val("ign_start_state", dbg_state, ST_NORM);
        check_val("ign_start_busy", busy, 1);
        check_val("ign_start_iter", iter_cnt, 0);
        #1 start = 1'b0;
        abort = 1'b1;
        m_norm_done = 1'b1;
        @(negedge clk_iter);
        check_val("abort_norm_state", dbg_state, ST_IDLE);
        check_val("abort_norm_iter", iter_cnt, 0);
        check_val("abort_norm_busy", busy, 0);
        check_val("abort_norm_go_fast", eng_if.go_fast, 0);
        #1 abort = 1'b0;
        m_norm_done = 1'b0;
        repeat (4) @(negedge clk_iter);
        check_val("abort_norm_no_conv", n_conv - b_conv, 0);
        check_val("abort_norm_idle", dbg_state, ST_IDLE);
        auto_en = 1'b1;

        // Asynchronous reset in the middle of RUN_FAST.
        clear_tables();
        lat_f[0] = STD_FAST;
        #1 start = 1'b1;
        @(negedge clk_iter);
        #1 start = 1'b0;
        repeat (5) @(negedge clk_iter);
        check_val("mid_go_fast", eng_if.go_fast, 1);
        check_val("mid_busy", busy, 1);
        @(posedge clk_iter);
        #2 rst_iter = 1'b1;
        #1 check_reset("rst_async");
        @(negedge clk_iter);
        #1 rst_iter = 1'b0;
        @(negedge clk_iter);
        check_val("rst_after_state", dbg_state, ST_IDLE);

`ifdef ICA_TIMEOUT_EN
        // Watchdog: normalization never answers.
        auto_en = 1'b0;
        clear_tables();
        lat_f[0] = 2;
        #1 start = 1'b1;
        @(negedge clk_iter);
        #1 start = 1'b0;
        k = 0;
        while (!eng_if.norm_start && k < 50) begin
            @(negedge clk_iter);
            k++;
        end
        check_val("tmo_norm_seen", eng_if.norm_start, 1);
        k = 0;
        while (!timeout_err && k < 100) begin
            @(negedge clk_iter);
            k++;
        end
        check_val("tmo_cycles", k, TMO);
        check_val("tmo_state", dbg_state, ST_ERR);
        check_val("tmo_go_fast", eng_if.go_fast, 0);
        check_val("tmo_busy", busy, 0);
        check_val("tmo_iter", iter_cnt, 0);
        #1 start = 1'b1;
        @(negedge clk_iter);
        check_val("tmo_restart_state", dbg_state, ST_KICK);
        check_val("tmo_restart_err", timeout_err, 0);
        check_val("tmo_restart_busy", busy, 1);
        #1 start = 1'b0;
        abort = 1'b1;
        @(negedge clk_iter);
        #1 abort = 1'b0;
        auto_en = 1'b1;
`endif

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
